// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-buffer entry layout used by the IF stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0: the word presented to IF/ID when no fetched word is available
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // PC of the first fetch after reset
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // One buffered fetch: the instruction word together with the PC it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} entries between imem and IF/ID.
// The head is read combinationally so the oldest entry is visible in the cycle it lands.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   i_srst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  // A flush discards everything, including a same-cycle push; a push into a
  // full buffer is only taken when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; no reset needed since occupancy is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk) begin
    if (i_srst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage: owns the PC, issues in-order word requests to
// the instruction memory, buffers returned words with their PCs and presents
// the oldest one to the IF/ID register. Redirects from EX flush the buffer and
// discard responses that are still in flight for the old path.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        FetchValidF
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_req_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_push;
  logic          w_pop;
  logic          w_grant;
  logic          w_discard;
  logic [31:0]   w_target;
  logic [CW:0]   w_credit_used;

  assign w_target = PCTargetE & 32'hFFFF_FFFC;

  // Buffer head drives the IF/ID inputs; a popped slot is usable this cycle
  assign FetchValidF = !w_empty;
  assign w_pop       = FetchValidF && !StallF;

  // Credits cover both buffered words and words still owed by memory, so a
  // response always has a slot. A slot freed by this cycle's pop counts as
  // available, which is what lets a 1-cycle memory sustain one word per cycle.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_count} - {{CW{1'b0}}, w_pop};

  assign imem_req  = !reset && !PCSrcE && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = r_req_pc;
  assign w_grant   = imem_req && imem_gnt;

  // Responses to requests from before a redirect are thrown away
  assign w_discard    = imem_rvalid && (r_drop != '0);
  assign w_push       = imem_rvalid && (r_drop == '0) && !PCSrcE && !reset;
  assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rdata};

  assign InstrF   = FetchValidF ? w_head.instr : NOP_INSTR;
  assign PCF      = FetchValidF ? w_head.pc : 32'h0;
  assign PCplus4F = FetchValidF ? (w_head.pc + 32'd4) : 32'h0;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fetch_fifo (
    .clk         (clk),
    .i_srst      (reset),
    .i_flush     (PCSrcE),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // PC, in-flight and drop tracking; a redirect takes priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_pc   <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      assert (!(imem_rvalid && (r_inflight == '0)));
      assert (!(w_push && w_full && !w_pop));
      if (PCSrcE) begin
        // No request issues this cycle, so only a same-cycle response retires;
        // every word still owed afterwards belongs to the abandoned path.
        r_req_pc   <= w_target;
        r_rsp_pc   <= w_target;
        r_inflight <= r_inflight - CW'(imem_rvalid);
        r_drop     <= r_inflight - CW'(imem_rvalid);
      end else begin
        if (w_grant) begin
          r_req_pc <= r_req_pc + 32'd4;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_discard) begin
          r_drop <= r_drop - CW'(1);
        end
        r_inflight <= r_inflight + CW'(w_grant) - CW'(imem_rvalid);
      end
    end
  end

endmodule
